pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_pkg.sv | 36 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared constants for the PLL reset sequencer: FSM encoding, default timing
// parameters and the sizing helper for the shared interval counter.
package pll_reset_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_PLL_RESET = 3'd0;
   localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
   localparam logic [STATE_W-1:0] ST_RELEASE   = 3'd3;
   localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;

   localparam int DEF_NUM_STAGES         = 4;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_STAGE_GAP          = 16;
   localparam int DEF_LOCK_TIMEOUT       = 65536;
   localparam int DEF_PLL_RST_CYCLES     = 8;

   localparam int RETRY_W = 4;
   localparam logic [RETRY_W-1:0] RETRY_MAX = 4'hF;

   // Normally clog2(lock_timeout)+1; grows only if another interval is longer,
   // so a short bench timeout cannot truncate the stability or release counts.
   function automatic int seq_cnt_width(input int lock_timeout,
                                        input int lock_stable,
                                        input int release_span,
                                        input int pll_rst_cycles);
      int m;
      m = lock_timeout;
      if (lock_stable > m)    m = lock_stable;
      if (release_span > m)   m = release_span;
      if (pll_rst_cycles > m) m = pll_rst_cycles;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal entering the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, qualifies lock, then releases downstream resets one
// stage at a time; tears everything down again on lock loss or software request.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int NUM_STAGES         = DEF_NUM_STAGES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int STAGE_GAP          = DEF_STAGE_GAP,
   parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
   parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  locked,
   input  logic                  sw_rst_req,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  ready,
   output logic [RETRY_W-1:0]    retry_cnt,
   output logic [STATE_W-1:0]    state_dbg
);

   localparam int CW = seq_cnt_width(LOCK_TIMEOUT, LOCK_STABLE_CYCLES,
                                     (NUM_STAGES - 1) * STAGE_GAP + 1, PLL_RST_CYCLES);

   localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_STAGES - 1) * STAGE_GAP);

   logic                locked_s;
   logic [STATE_W-1:0]  state;
   logic [CW-1:0]       cnt;
   logic                armed;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign state_dbg = state;

   // sw_rst_req is a single-cycle strobe sampled on the clk edge; there is no
   // acknowledge, and a strobe seen in PLL_RESET or WAIT_LOCK is simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PLL_RESET;
         cnt         <= '0;
         armed       <= 1'b0;
         pll_rst     <= 1'b1;
         stage_rst_n <= '0;
         ready       <= 1'b0;
         retry_cnt   <= '0;
      end else begin
         case (state)
            ST_PLL_RESET: begin
               // The first edge after reset release starts the pulse count.
               if (!armed) begin
                  armed <= 1'b1;
               end else if (cnt == RST_LAST) begin
                  state   <= ST_WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state   <= ST_PLL_RESET;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_STABLE: begin
               if (!locked_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
               end else if (sw_rst_req) begin
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state <= ST_RELEASE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_RELEASE, ST_RUN: begin
               // Lock loss outranks a coincident software request.
               if (!locked_s) begin
                  state       <= ST_WAIT_LOCK;
                  cnt         <= '0;
                  stage_rst_n <= '0;
                  ready       <= 1'b0;
               end else if (sw_rst_req) begin
                  state       <= ST_STABLE;
                  cnt         <= '0;
                  stage_rst_n <= '0;
                  ready       <= 1'b0;
               end else if (state == ST_RELEASE) begin
                  for (int k = 0; k < NUM_STAGES; k++) begin
                     if (cnt == CW'(k * STAGE_GAP)) stage_rst_n[k] <= 1'b1;
                  end
                  if (cnt == RELEASE_LAST) begin
                     state <= ST_RUN;
                     cnt   <= '0;
                     ready <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            default: begin
               state       <= ST_PLL_RESET;
               cnt         <= '0;
               pll_rst     <= 1'b1;
               stage_rst_n <= '0;
               ready       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected output-change events are
// queued by the stimulus and checked by an independent monitor.
module tb_pll_reset_sequencer;
   import pll_reset_pkg::*;

   localparam int W = 42;

   logic clk = 1'b0;
   logic rst_n;
   logic locked;
   logic sw_rst_req;
   logic pll_rst;
   logic [3:0] stage_rst_n;
   logic ready;
   logic [3:0] retry_cnt;
   logic [2:0] state_dbg;

   int edge_idx;
   int checks;
   int errors;
   logic mon_en;
   logic [W-1:0] exp_q[$];
   logic [9:0] cur_outs;

   assign cur_outs = {pll_rst, stage_rst_n, ready, retry_cnt};

   pll_reset_sequencer #(
      .NUM_STAGES         (4),
      .LOCK_STABLE_CYCLES (1024),
      .STAGE_GAP          (16),
      .LOCK_TIMEOUT       (64),
      .PLL_RST_CYCLES     (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .locked      (locked),
      .sw_rst_req  (sw_rst_req),
      .pll_rst     (pll_rst),
      .stage_rst_n (stage_rst_n),
      .ready       (ready),
      .retry_cnt   (retry_cnt),
      .state_dbg   (state_dbg)
   );

   // clock / reset-relative edge index
   always #10 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_idx <= -1;
      else        edge_idx <= edge_idx + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time %0t reached, edge %0d", $time, edge_idx);
      $fatal(1, "watchdog expired");
   end

   // driver helpers
   task automatic push_exp(input int cyc, input logic p, input logic [3:0] s,
                           input logic r, input logic [3:0] rc);
      exp_q.push_back({cyc, p, s, r, rc});
   endtask

   task automatic goto_edge(input int e);
      while (edge_idx < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      locked     = 1'b0;
      sw_rst_req = 1'b0;

      fork
         begin : stimulus
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_val("reset_pll_rst", pll_rst, 1);
            check_val("reset_stage_rst_n", stage_rst_n, 0);
            check_val("reset_ready", ready, 0);
            check_val("reset_retry_cnt", retry_cnt, 0);
            check_val("reset_state", state_dbg, ST_PLL_RESET);
            mon_en = 1'b1;

            // nominal: locked rises after edge 19
            push_exp(8,    1'b0, 4'b0000, 1'b0, 4'd0);
            push_exp(1047, 1'b0, 4'b0001, 1'b0, 4'd0);
            push_exp(1063, 1'b0, 4'b0011, 1'b0, 4'd0);
            push_exp(1079, 1'b0, 4'b0111, 1'b0, 4'd0);
            push_exp(1095, 1'b0, 4'b1111, 1'b1, 4'd0);
            @(negedge clk);
            rst_n = 1'b1;
            goto_edge(19);
            locked = 1'b1;

            // lock loss in RUN, then full re-sequence
            push_exp(1123, 1'b0, 4'b0000, 1'b0, 4'd0);
            push_exp(2158, 1'b0, 4'b0001, 1'b0, 4'd0);
            push_exp(2174, 1'b0, 4'b0011, 1'b0, 4'd0);
            push_exp(2190, 1'b0, 4'b0111, 1'b0, 4'd0);
            push_exp(2206, 1'b0, 4'b1111, 1'b1, 4'd0);
            goto_edge(1120);
            locked = 1'b0;
            goto_edge(1130);
            locked = 1'b1;

            // software restart in RUN: back through STABLE, no pll_rst
            push_exp(2221, 1'b0, 4'b0000, 1'b0, 4'd0);
            push_exp(3246, 1'b0, 4'b0001, 1'b0, 4'd0);
            push_exp(3262, 1'b0, 4'b0011, 1'b0, 4'd0);
            push_exp(3278, 1'b0, 4'b0111, 1'b0, 4'd0);
            push_exp(3294, 1'b0, 4'b1111, 1'b1, 4'd0);
            goto_edge(2220);
            sw_rst_req = 1'b1;
            goto_edge(2221);
            sw_rst_req = 1'b0;

            // request coincident with lock loss: WAIT_LOCK, timeout 64 cycles later
            push_exp(3313, 1'b0, 4'b0000, 1'b0, 4'd0);
            push_exp(3377, 1'b1, 4'b0000, 1'b0, 4'd1);
            push_exp(3385, 1'b0, 4'b0000, 1'b0, 4'd1);
            goto_edge(3310);
            locked = 1'b0;
            goto_edge(3312);
            sw_rst_req = 1'b1;
            goto_edge(3313);
            sw_rst_req = 1'b0;
            goto_edge(3390);
            locked = 1'b1;

            // 3-cycle glitch at STABLE count 500 restarts qualification
            push_exp(4924, 1'b0, 4'b0001, 1'b0, 4'd1);
            push_exp(4940, 1'b0, 4'b0011, 1'b0, 4'd1);
            goto_edge(3893);
            locked = 1'b0;
            goto_edge(3896);
            locked = 1'b1;

            // asynchronous reset with two stages released
            push_exp(-1, 1'b1, 4'b0000, 1'b0, 4'd0);
            goto_edge(4945);
            rst_n = 1'b0;
            #2;
            check_val("async_pll_rst", pll_rst, 1);
            check_val("async_stage_rst_n", stage_rst_n, 0);
            check_val("async_ready", ready, 0);
            check_val("async_retry_cnt", retry_cnt, 0);
            check_val("async_state", state_dbg, ST_PLL_RESET);
            repeat (3) @(posedge clk);
            locked = 1'b0;

            // lock never arrives: 8-cycle pll_rst every 72 cycles, retry saturates
            push_exp(8, 1'b0, 4'b0000, 1'b0, 4'd0);
            for (int n = 1; n <= 17; n++) begin
               push_exp(72 * n,     1'b1, 4'b0000, 1'b0, (n > 15) ? 4'd15 : 4'(n));
               push_exp(72 * n + 8, 1'b0, 4'b0000, 1'b0, (n > 15) ? 4'd15 : 4'(n));
            end
            @(negedge clk);
            rst_n = 1'b1;
            goto_edge(1240);
            @(negedge clk);
            #2;
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL queue_drain: %0d events never seen, expected 0", exp_q.size());
            end
         end

         begin : monitor
            logic [9:0]   prev;
            logic         primed;
            logic [W-1:0] e;
            int           ecyc;
            primed = 1'b0;
            prev   = '0;
            forever begin
               @(negedge clk);
               if (mon_en) begin
                  if (!primed) begin
                     prev   = cur_outs;
                     primed = 1'b1;
                  end else if (cur_outs !== prev) begin
                     checks++;
                     if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: cycle %0d outs %b, no event expected",
                                 edge_idx, cur_outs);
                     end else begin
                        e    = exp_q.pop_front();
                        ecyc = e[41:10];
                        if (ecyc != edge_idx || e[9:0] !== cur_outs) begin
                           errors++;
                           $display("FAIL event: cycle %0d outs %b, expected cycle %0d outs %b",
                                    edge_idx, cur_outs, ecyc, e[9:0]);
                        end
                     end
                     prev = cur_outs;
                  end
               end
            end
         end
      join_any

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
